term_write_ctrl: RTL and testbench
==================================

TERM_WRITE_CTRL -- requirements
Module: term_write_ctrl

Interface
REQ-001 Parameter ROWS, default 30, number of visible text rows.
REQ-002 Parameter COLS, default 70, number of text columns.
REQ-003 Parameter BLINK_LOG2, default 24, log2 of the cursor half-period in clocks (used only under TERM_CURSOR_BLINK_EN).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 kb_valid  input  1  keyboard character available.
REQ-007 kb_data  input  8  ASCII code.
REQ-008 kb_ready  output  1  controller accepts a character this cycle.
REQ-009 clear_req  input  1  single-cycle request to blank the screen.
REQ-010 vm_we  output  1  vmem write strobe.
REQ-011 vm_addr  output  12  vmem address {col[6:0], row[4:0]}.
REQ-012 vm_wdata  output  8  vmem write data.
REQ-013 cur_row  output  5  cursor row; cur_col output 7, cursor column.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 cursor_on  output  1  cursor visibility for the display path.

Function
REQ-016 States: IDLE, PUT, CLEAR, CLRLINE; all outputs registered.
REQ-017 kb_ready SHALL be 1 only in IDLE with clear_req low; a transfer occurs when kb_valid and kb_ready are both 1.
REQ-018 clear_req in IDLE SHALL win over a simultaneous kb_valid (no transfer that cycle); clear_req outside IDLE SHALL be ignored.
REQ-019 Printable 0x20-0x7E: next cycle PUT, vm_we=1, vm_addr={cur_col,cur_row}, vm_wdata=kb_data; col advances; at col COLS-1 it wraps to col 0, next row.
REQ-020 0x0A: col=0, row+1, then CLRLINE on the new row; 0x0D: col=0, no write; 0x08 backspace: cursor moves back one cell and PUT writes 0x20 there.
REQ-021 Backspace at (0,0) SHALL be a no-op; at col 0 of row r>0 it SHALL go to (r-1, COLS-1).
REQ-022 Any row advance past ROWS-1 SHALL wrap to row 0; each row advance (wrap or newline) SHALL enter CLRLINE.
REQ-023 CLRLINE: COLS consecutive cycles writing 0x20 to cols 0..COLS-1 of the cursor row, then IDLE.
REQ-024 CLEAR: ROWS*COLS consecutive writes of 0x20, row-major (col inner), then cursor (0,0), IDLE.
REQ-025 Other codes SHALL be consumed with no write and no cursor change.
REQ-026 vm_we SHALL be 0 in IDLE; unused rows ROWS..31 are never written.

Reset
REQ-027 While rst=0: state CLEAR at (row 0, col 0), cursor (0,0), vm_we=0, kb_ready=0, busy=1, cursor_on=1, blink counter 0.
REQ-028 First CLEAR write SHALL occur on the first rising edge after rst deasserts; reset mid-operation aborts and restarts CLEAR.

Configuration
REQ-029 Macro TERM_CURSOR_BLINK_EN defined: cursor_on toggles every 2^BLINK_LOG2 clocks and is forced 1 for the cycle after any transfer.
REQ-030 Macro undefined: cursor_on SHALL be constant 1 and no blink counter exists.

Structure
REQ-031 Package term_pkg SHALL hold ROWS/COLS defaults, CH_BLANK=0x20, CH_BS=0x08, CH_LF=0x0A, CH_CR=0x0D and the state enum.
REQ-032 One sub-module term_sweep_cnt (row/col sweep counter with start, last-col and last-cell outputs) SHALL serve CLEAR and CLRLINE.

Verification
REQ-033 Release reset -> 2100 writes of 0x20, busy low on cycle 2101, kb_ready=1, cursor (0,0).
REQ-034 Send 'B' then 'A' -> vm_addr 0x000 data 0x42, vm_addr 0x020 data 0x41, cursor (0,2).
REQ-035 Cursor (0,69), send 'X' -> write at {69,0}, cursor (1,0), 70 blank writes on row 1.
REQ-036 Cursor (29,5), send 0x0A -> cursor (0,0), row 0 blanked; then 0x08 -> no write, cursor (0,0).
REQ-037 clear_req and kb_valid same IDLE cycle -> kb_ready=0, no PUT, 2100-cycle CLEAR, character taken afterwards.

Source files
------------

// File: rtl/term_pkg.sv
// Shared definitions for the terminal write controller.
//   ROWS_DEF / COLS_DEF : default visible text geometry
//   CH_*                : control and fill character codes
//   term_state_e        : controller state encoding
//   is_printable()      : true for the printable ASCII range 0x20..0x7E
package term_pkg;

  localparam int ROWS_DEF = 30;
  localparam int COLS_DEF = 70;

  localparam logic [7:0] CH_BLANK = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PUT     = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_CLRLINE = 2'd3
  } term_state_e;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= 8'h20) && (ch <= 8'h7E);
  endfunction

endpackage

// File: rtl/term_sweep_cnt.sv
// Row/column sweep counter used to blank either a single line or the whole
// screen. Column is the inner (fast) index.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset (clears to 0,0)
//   start_i           : load position (start_row_i, col 0)
//   start_row_i       : row to load on start
//   step_i            : advance one cell (col+1, or col 0 / next row)
//   row_o, col_o      : current sweep position
//   last_col_o        : position is in the last column
//   last_cell_o       : position is the last cell of the visible screen
module term_sweep_cnt
  import term_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [4:0] start_row_i,
  input  logic       step_i,
  output logic [4:0] row_o,
  output logic [6:0] col_o,
  output logic       last_col_o,
  output logic       last_cell_o
);

  logic [4:0] row_q, row_d;
  logic [6:0] col_q, col_d;

  assign last_col_o  = (col_q == 7'(COLS - 1));
  assign last_cell_o = last_col_o && (row_q == 5'(ROWS - 1));
  assign row_o       = row_q;
  assign col_o       = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (start_i) begin
      row_d = start_row_i;
      col_d = '0;
    end else if (step_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/term_write_ctrl.sv
// Terminal write controller: turns keyboard characters into video-memory
// writes, tracks the cursor, and blanks lines / the whole screen.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   kb_valid, kb_data   : keyboard character offer
//   kb_ready            : character accepted when kb_valid & kb_ready
//   clear_req           : one-cycle request to blank the screen (IDLE only)
//   vm_we/addr/wdata    : video memory write port, addr = {col[6:0], row[4:0]}
//   cur_row, cur_col    : cursor position
//   busy                : controller not in IDLE
//   cursor_on           : cursor visibility
// Build option: define TERM_CURSOR_BLINK_EN to make cursor_on blink with a
// half-period of 2^BLINK_LOG2 clocks; otherwise cursor_on is constant 1.
module term_write_ctrl
  import term_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int BLINK_LOG2 = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  input  logic        clear_req,
  output logic        vm_we,
  output logic [11:0] vm_addr,
  output logic [7:0]  vm_wdata,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy,
  output logic        cursor_on
);

  term_state_e state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;   // sweep has issued its final write
  logic        adv_q, adv_d;     // PUT wrapped to a new row, blank it next

  logic        sw_start;
  logic [4:0]  sw_start_row;
  logic        sw_step;
  logic [4:0]  sw_row;
  logic [6:0]  sw_col;
  logic        sw_last_col;
  logic        sw_last_cell;

  logic        xfer;
  logic [4:0]  row_inc;
  logic [4:0]  bs_row;
  logic [6:0]  bs_col;

  term_sweep_cnt #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_sweep (
    .clk         (clk),
    .rst         (rst),
    .start_i     (sw_start),
    .start_row_i (sw_start_row),
    .step_i      (sw_step),
    .row_o       (sw_row),
    .col_o       (sw_col),
    .last_col_o  (sw_last_col),
    .last_cell_o (sw_last_cell)
  );

  // A pending clear request takes precedence over the keyboard, so it must
  // withdraw ready in the same cycle it is raised.
  assign kb_ready = ready_q & ~clear_req;
  assign xfer     = kb_valid & kb_ready;

  assign row_inc = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
  assign bs_row  = (col_q == 7'd0) ? row_q - 5'd1 : row_q;
  assign bs_col  = (col_q == 7'd0) ? 7'(COLS - 1) : col_q - 7'd1;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done_d       = done_q;
    adv_d        = adv_q;
    sw_start     = 1'b0;
    sw_start_row = row_q;
    sw_step      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d      = ST_CLEAR;
          sw_start     = 1'b1;
          sw_start_row = 5'd0;
          done_d       = 1'b0;
        end else if (xfer) begin
          if (is_printable(kb_data)) begin
            we_d    = 1'b1;
            addr_d  = {col_q, row_q};
            wdata_d = kb_data;
            state_d = ST_PUT;
            if (col_q == 7'(COLS - 1)) begin
              col_d = '0;
              row_d = row_inc;
              adv_d = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
              adv_d = 1'b0;
            end
          end else if (kb_data == CH_LF) begin
            col_d        = '0;
            row_d        = row_inc;
            state_d      = ST_CLRLINE;
            sw_start     = 1'b1;
            sw_start_row = row_inc;
            done_d       = 1'b0;
          end else if (kb_data == CH_CR) begin
            col_d = '0;
          end else if (kb_data == CH_BS) begin
            if (row_q != 5'd0 || col_q != 7'd0) begin
              row_d   = bs_row;
              col_d   = bs_col;
              we_d    = 1'b1;
              addr_d  = {bs_col, bs_row};
              wdata_d = CH_BLANK;
              state_d = ST_PUT;
              adv_d   = 1'b0;
            end
          end
        end
      end

      ST_PUT: begin
        if (adv_q) begin
          state_d      = ST_CLRLINE;
          sw_start     = 1'b1;
          sw_start_row = row_q;
          done_d       = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLRLINE: begin
        if (!done_q) begin
          we_d    = 1'b1;
          addr_d  = {sw_col, sw_row};
          wdata_d = CH_BLANK;
          sw_step = 1'b1;
          done_d  = sw_last_col;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        if (!done_q) begin
          we_d    = 1'b1;
          addr_d  = {sw_col, sw_row};
          wdata_d = CH_BLANK;
          sw_step = 1'b1;
          done_d  = sw_last_cell;
        end else begin
          state_d = ST_IDLE;
          row_d   = '0;
          col_d   = '0;
        end
      end

      default: state_d = ST_CLEAR;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= CH_BLANK;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      adv_q   <= adv_d;
    end
  end

  assign vm_we    = we_q;
  assign vm_addr  = addr_q;
  assign vm_wdata = wdata_q;
  assign cur_row  = row_q;
  assign cur_col  = col_q;
  assign busy     = busy_q;

`ifdef TERM_CURSOR_BLINK_EN
  logic [BLINK_LOG2-1:0] blink_q;
  logic                  cursor_on_q;

  // Any accepted character shows the cursor immediately; blinking resumes
  // from the visible phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q     <= '0;
      cursor_on_q <= 1'b1;
    end else begin
      blink_q <= blink_q + 1'b1;
      if (xfer) begin
        cursor_on_q <= 1'b1;
      end else if (&blink_q) begin
        cursor_on_q <= ~cursor_on_q;
      end
    end
  end

  assign cursor_on = cursor_on_q;
`else
  assign cursor_on = 1'b1;
`endif

endmodule

// File: tb/tb_term_write_ctrl.sv
module tb_term_write_ctrl;

  localparam int ROWS = 30;
  localparam int COLS = 70;

  logic        clk;
  logic        rst;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        clear_req;
  logic        vm_we;
  logic [11:0] vm_addr;
  logic [7:0]  vm_wdata;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;
  logic        cursor_on;

  term_write_ctrl #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .BLINK_LOG2 (24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kb_valid  (kb_valid),
    .kb_data   (kb_data),
    .kb_ready  (kb_ready),
    .clear_req (clear_req),
    .vm_we     (vm_we),
    .vm_addr   (vm_addr),
    .vm_wdata  (vm_wdata),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .busy      (busy),
    .cursor_on (cursor_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int base_cyc = 0;
  int txn = 0;

  logic [19:0] obs[$];
  int          stamps[$];
  logic [19:0] exp_q[$];
  int          exp_row = 0;
  int          exp_col = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed write stream, sampled mid-cycle.
  always @(negedge clk) begin
    if (vm_we) begin
      obs.push_back({vm_addr, vm_wdata});
      stamps.push_back(cyc - base_cyc);
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [19:0] wr(input int r, input int c, input logic [7:0] d);
    return {7'(c), 5'(r), d};
  endfunction

  function automatic void model_blank_row(input int r);
    for (int c = 0; c < COLS; c++) exp_q.push_back(wr(r, c, 8'h20));
  endfunction

  function automatic void model_next_row();
    exp_row = (exp_row + 1) % ROWS;
    model_blank_row(exp_row);
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++) model_blank_row(r);
    exp_row = 0;
    exp_col = 0;
  endfunction

  function automatic void model_char(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      exp_q.push_back(wr(exp_row, exp_col, ch));
      exp_col++;
      if (exp_col == COLS) begin
        exp_col = 0;
        model_next_row();
      end
    end else if (ch == 8'h0A) begin
      exp_col = 0;
      model_next_row();
    end else if (ch == 8'h0D) begin
      exp_col = 0;
    end else if (ch == 8'h08) begin
      if (exp_row != 0 || exp_col != 0) begin
        if (exp_col == 0) begin
          exp_row--;
          exp_col = COLS - 1;
        end else begin
          exp_col--;
        end
        exp_q.push_back(wr(exp_row, exp_col, 8'h20));
      end
    end
  endfunction

  function automatic logic [7:0] rand_char();
    logic [7:0] v;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: v = 8'($urandom_range(32, 126));
      6:       v = 8'h0A;
      7:       v = 8'h0D;
      8:       v = 8'h08;
      default: v = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7))
                                               : 8'($urandom_range(127, 255));
    endcase
    return v;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic send_char(input logic [7:0] ch);
    int n;
    n = 0;
    while (kb_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", kb_ready, 1);
    obs.delete();
    stamps.delete();
    kb_valid = 1'b1;
    kb_data  = ch;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || kb_ready !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("idle_busy", busy, 0);
    check("idle_we", vm_we, 0);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      check({tag, "_write"}, obs[i], exp_q[i]);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, cur_row, exp_row);
    check({tag, "_col"}, cur_col, exp_col);
  endtask

  task automatic do_txn(input logic [7:0] ch, input bit pulse_clr);
    exp_q.delete();
    model_char(ch);
    send_char(ch);
    if (pulse_clr) begin
      // busy here, so the request must be ignored
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
    end
    wait_idle(400);
    compare_writes("txn");
    check_cursor("txn");
    txn++;
    $display("txn %0d: char 0x%02h clr=%0d writes=%0d cursor=(%0d,%0d)",
             txn, ch, pulse_clr, obs.size(), cur_row, cur_col);
  endtask

  task automatic release_and_clear(input string tag);
    int n;
    obs.delete();
    stamps.delete();
    exp_q.delete();
    model_clear();
    base_cyc = cyc;
    rst = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 2300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_cycle"}, cyc - base_cyc, 2101);
    check({tag, "_ready"}, kb_ready, 1);
    if (stamps.size() > 0) begin
      check({tag, "_first_cyc"}, stamps[0], 1);
      check({tag, "_last_cyc"}, stamps[stamps.size() - 1], 2100);
    end
    compare_writes(tag);
    check_cursor(tag);
    txn++;
    $display("txn %0d: reset clear writes=%0d cursor=(%0d,%0d)", txn, obs.size(), cur_row, cur_col);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [7:0] ch;
    rst       = 1'b1;
    kb_valid  = 1'b0;
    kb_data   = 8'h00;
    clear_req = 1'b0;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_we", vm_we, 0);
    check("rst_ready", kb_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_cursor_on", cursor_on, 1);
    check("rst_row", cur_row, 0);
    check("rst_col", cur_col, 0);

    release_and_clear("boot");

    // 'B' then 'A' from home
    do_txn(8'h42, 1'b0);
    do_txn(8'h41, 1'b0);
    check("ba_row", cur_row, 0);
    check("ba_col", cur_col, 2);

    // fill to the last column, then wrap with 'X'
    while (exp_col < COLS - 1) do_txn(8'($urandom_range(32, 126)), 1'b0);
    do_txn(8'h58, 1'b0);
    check("wrap_row", cur_row, 1);
    check("wrap_col", cur_col, 0);

    // reach (29,5), newline wraps to row 0, backspace at home is a no-op
    while (exp_row != ROWS - 1) do_txn(8'h0A, 1'b0);
    for (int i = 0; i < 5; i++) do_txn(8'($urandom_range(32, 126)), 1'b0);
    check("pos_row", cur_row, ROWS - 1);
    check("pos_col", cur_col, 5);
    do_txn(8'h0A, 1'b1);
    if (stamps.size() > 0) check("lf_contig", stamps[stamps.size() - 1] - stamps[0], COLS - 1);
    check("lf_row", cur_row, 0);
    do_txn(8'h08, 1'b0);
    check("bs_home_writes", obs.size(), 0);

    // clear request and character in the same IDLE cycle
    exp_q.delete();
    model_clear();
    model_char(8'h5A);
    @(negedge clk);
    obs.delete();
    stamps.delete();
    clear_req = 1'b1;
    kb_valid  = 1'b1;
    kb_data   = 8'h5A;
    #1 check("clr_ready_low", kb_ready, 0);
    @(negedge clk);
    clear_req = 1'b0;
    check("clr_busy", busy, 1);
    n = 0;
    while (kb_ready !== 1'b1 && n < 2300) begin
      @(negedge clk);
      n++;
    end
    check("clr_ready_back", kb_ready, 1);
    @(negedge clk);
    kb_valid = 1'b0;
    wait_idle(400);
    compare_writes("clr");
    check_cursor("clr");
    txn++;
    $display("txn %0d: clear+char writes=%0d cursor=(%0d,%0d)", txn, obs.size(), cur_row, cur_col);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      ch = rand_char();
      do_txn(ch, (ch == 8'h0A) && ($urandom_range(0, 1) != 0));
    end

    // reset in the middle of a line blank restarts a full clear
    send_char(8'h0A);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_we", vm_we, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_row", cur_row, 0);
    release_and_clear("midrst");

    do_txn(8'h21, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
